// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the opcode map, the sequencer state encoding and the helpers that
// split an 8-bit program word {opcode[3:0], operand[3:0]} into its fields.
package seq_pkg;

    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_ULA_MAX = 4'hB;
    localparam logic [3:0] OP_STORE   = 4'hC;
    localparam logic [3:0] OP_SHOW    = 4'hD;
    localparam logic [3:0] OP_LOADA   = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // ST_PAUSE is only reachable when single-step support is built in.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_ALU,
        ST_WAIT_ALU,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_NEXT,
        ST_HALT,
        ST_PAUSE
    } seq_state_t;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] word);
        return word[7:4];
    endfunction

    function automatic logic [3:0] instr_operand(input logic [INSTR_W-1:0] word);
        return word[3:0];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier for the instruction sequencer.
// Ports:
//   opcode   in   4  opcode field of the program word
//   is_alu   out  1  ULA operation (0x0..0xB)
//   is_store out  1  store ULA result to RAM (0xC)
//   is_show  out  1  RAM word to LEDs (0xD)
//   is_load  out  1  RAM word to register A (0xE)
//   is_halt  out  1  halt (0xF)
module instr_decoder (
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_store,
    output logic       is_show,
    output logic       is_load,
    output logic       is_halt
);
    import seq_pkg::*;

    assign is_alu   = (opcode <= OP_ULA_MAX);
    assign is_store = (opcode == OP_STORE);
    assign is_show  = (opcode == OP_SHOW);
    assign is_load  = (opcode == OP_LOADA);
    assign is_halt  = (opcode == OP_HALT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer sitting between the program ROM,
// the ULA and the data RAM.
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add the `step` input and a
// PAUSE state after every instruction; a step pulse resumes with the next fetch.
//
// Ports:
//   clock      in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   start      in   1           leave IDLE/HALT and run from pc=0
//   step       in   1           (SEQ_SINGLE_STEP_EN only) leave PAUSE
//   prog_addr  out  PC_WIDTH    ROM address (= pc)
//   prog_data  in   8           ROM word, valid one cycle after prog_addr
//   alu_en     out  1           one-cycle ULA execute pulse
//   alu_op     out  4           opcode to ULA
//   alu_done   in   1           ULA finished
//   alu_result in   DATA_WIDTH  ULA output register
//   mem_addr   out  4           RAM address (= operand)
//   mem_rd     out  1           RAM read, held RAM_LAT cycles
//   mem_we     out  1           RAM write strobe
//   mem_wdata  out  DATA_WIDTH  RAM write data
//   mem_rdata  in   DATA_WIDTH  RAM read data
//   led_out    out  DATA_WIDTH  LED register
//   rega_load  out  1           register A load pulse
//   rega_data  out  DATA_WIDTH  register A value
//   busy       out  1           not in IDLE/HALT
//   halted     out  1           in HALT
//   error      out  1           sticky ULA timeout flag
//
// State table:
//   ST_IDLE     | waiting for start after reset
//   ST_FETCH    | prog_addr = pc presented to ROM
//   ST_DECODE   | ROM word valid; classify and latch into ir
//   ST_EXEC_ALU | alu_en pulse
//   ST_WAIT_ALU | waiting for alu_done, bounded by ALU_TIMEOUT
//   ST_MEM_WR   | mem_we pulse with captured ULA result
//   ST_MEM_RD   | mem_rd held RAM_LAT cycles, data captured on last cycle
//   ST_NEXT     | pc increment (rega_load pulse for opcode 0xE)
//   ST_HALT     | stopped; start restarts from pc=0
//   ST_PAUSE    | single-step hold between instructions
module instr_sequencer import seq_pkg::*; #(
    parameter int PC_WIDTH    = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LAT     = 1,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [PC_WIDTH-1:0]   prog_addr,
    input  logic [INSTR_W-1:0]    prog_data,
    output logic                  alu_en,
    output logic [3:0]            alu_op,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [3:0]            mem_addr,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] led_out,
    output logic                  rega_load,
    output logic [DATA_WIDTH-1:0] rega_data,
    output logic                  busy,
    output logic                  halted,
    output logic                  error
);

    // One down-counter serves both the RAM latency and the ULA timeout;
    // the two are never active at the same time.
    localparam int TMR_MAX = (ALU_TIMEOUT > RAM_LAT) ? ALU_TIMEOUT : RAM_LAT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ALU_TMR_LOAD = TMR_W'(ALU_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RAM_TMR_LOAD = TMR_W'(RAM_LAT - 1);

    seq_state_t            state, state_nxt;
    logic [PC_WIDTH-1:0]   pc;
    logic [INSTR_W-1:0]    ir;
    logic [TMR_W-1:0]      tmr;
    logic                  tmr_zero;

    logic dec_alu, dec_store, dec_show, dec_load, dec_halt;

    // Decode looks at the ROM word directly so the branch is taken in DECODE
    // itself; ir only holds the operand/opcode for the later states.
    instr_decoder u_decoder (
        .opcode   (instr_opcode(prog_data)),
        .is_alu   (dec_alu),
        .is_store (dec_store),
        .is_show  (dec_show),
        .is_load  (dec_load),
        .is_halt  (dec_halt)
    );

    assign tmr_zero  = (tmr == '0);
    assign prog_addr = pc;
    assign mem_addr  = instr_operand(ir);
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are qualified with reset_n so they fall together with it.
    always_comb begin
        state_nxt = state;
        alu_en    = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        rega_load = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (dec_alu)                   state_nxt = ST_EXEC_ALU;
                else if (dec_store)            state_nxt = ST_MEM_WR;
                else if (dec_show || dec_load) state_nxt = ST_MEM_RD;
                else if (dec_halt)             state_nxt = ST_HALT;
                else                           state_nxt = ST_IDLE;
            end
            ST_EXEC_ALU: begin
                alu_en    = reset_n;
                state_nxt = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                if (alu_done)      state_nxt = ST_NEXT;
                else if (tmr_zero) state_nxt = ST_HALT;
            end
            ST_MEM_WR: begin
                mem_we    = reset_n;
                state_nxt = ST_NEXT;
            end
            ST_MEM_RD: begin
                mem_rd = reset_n;
                if (tmr_zero) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                rega_load = reset_n && (instr_opcode(ir) == OP_LOADA);
`ifdef SEQ_SINGLE_STEP_EN
                state_nxt = ST_PAUSE;
`else
                state_nxt = ST_FETCH;
`endif
            end
            ST_PAUSE: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (step) state_nxt = ST_FETCH;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            ir        <= '0;
            tmr       <= '0;
            alu_op    <= '0;
            mem_wdata <= '0;
            led_out   <= '0;
            rega_data <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        error <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    ir <= prog_data;
                    if (dec_alu)               alu_op    <= instr_opcode(prog_data);
                    if (dec_store)             mem_wdata <= alu_result;
                    if (dec_show || dec_load)  tmr       <= RAM_TMR_LOAD;
                end
                ST_EXEC_ALU: tmr <= ALU_TMR_LOAD;
                ST_WAIT_ALU: begin
                    if (!alu_done) begin
                        if (tmr_zero) error <= 1'b1;
                        else          tmr   <= tmr - TMR_W'(1);
                    end
                end
                ST_MEM_RD: begin
                    if (tmr_zero) begin
                        if (instr_opcode(ir) == OP_SHOW) led_out   <= mem_rdata;
                        else                             rega_data <= mem_rdata;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_NEXT: pc <= pc + PC_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule
